sdhci_obi_reg_adapter: RTL and testbench



---
 rtl/sdhci_obi_reg_adapter_if.sv | 48 ++++
 rtl/sdhci_obi_reg_adapter.sv | 133 +++++++++++++
 tb/tb_sdhci_obi_reg_adapter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sdhci_obi_reg_adapter_if.sv
// ============================================================================
// Module : sdhci_obi_if / sdhci_reg_if
// Brief  : OBI subordinate bus and SDHCI register bus used by the adapter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface sdhci_obi_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      req;
  logic                      gnt;
  logic [ADDR_WIDTH-1:0]     addr;
  logic                      we;
  logic [DATA_WIDTH/8-1:0]   be;
  logic [DATA_WIDTH-1:0]     wdata;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      err;

  modport master (output req, addr, we, be, wdata, rready,
                  input  gnt, rvalid, rdata, err);
  modport slave  (input  req, addr, we, be, wdata, rready,
                  output gnt, rvalid, rdata, err);
endinterface

interface sdhci_reg_if #(
  parameter int REG_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH     = 32
);
  logic                      valid;
  logic                      ready;
  logic [REG_ADDR_WIDTH-1:0] addr;
  logic                      we;
  logic [DATA_WIDTH/8-1:0]   be;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      error;

  modport master (output valid, addr, we, be, wdata,
                  input  ready, rdata, error);
  modport slave  (input  valid, addr, we, be, wdata,
                  output ready, rdata, error);
endinterface

`default_nettype wire

// File: rtl/sdhci_obi_reg_adapter.sv
// ============================================================================
// Module : sdhci_obi_reg_adapter
// Brief  : OBI subordinate to SDHCI register bus bridge, one access in flight,
//          with address-range check and register ready timeout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sdhci_obi_reg_adapter #(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          REG_ADDR_WIDTH = 8,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = 32'hBADCAB1E
) (
  input  wire logic   clk_i,
  input  wire logic   rst_ni,
  sdhci_obi_if.slave  obi,
  sdhci_reg_if.master regb
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]                r_state;
  logic [1:0]                w_next_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [REG_ADDR_WIDTH-1:0] r_addr;
  logic                      r_we;
  logic [DATA_WIDTH/8-1:0]   r_be;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [DATA_WIDTH-1:0]     r_rdata;
  logic                      r_err;

  logic w_gnt;
  logic w_hs;
  logic w_oor;
  logic w_cnt_last;

  assign w_gnt      = (r_state == S_IDLE);
  assign w_hs       = obi.req && w_gnt;
  assign w_oor      = |obi.addr[ADDR_WIDTH-1:REG_ADDR_WIDTH];
  // Last permitted ACCESS cycle; a ready arriving here still completes normally.
  assign w_cnt_last = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_next_state = w_oor ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (regb.ready || w_cnt_last) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        if (obi.rready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    obi.gnt    = w_gnt;
    obi.rvalid = (r_state == S_RESP);
    regb.valid = (r_state == S_ACCESS);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_hs) begin
            r_addr  <= obi.addr[REG_ADDR_WIDTH-1:0];
            r_we    <= obi.we;
            r_be    <= obi.be;
            r_wdata <= obi.wdata;
            r_err   <= w_oor;
            r_rdata <= (w_oor && !obi.we) ? ERR_DATA : '0;
          end
        end
        S_ACCESS: begin
          if (regb.ready) begin
            r_rdata <= r_we ? '0 : regb.rdata;
            r_err   <= regb.error;
          end else if (w_cnt_last) begin
            r_rdata <= r_we ? '0 : ERR_DATA;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign regb.addr  = {r_addr[REG_ADDR_WIDTH-1:2], 2'b00};
  assign regb.we    = r_we;
  assign regb.be    = r_be;
  assign regb.wdata = r_wdata;
  assign obi.rdata  = r_rdata;
  assign obi.err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sdhci_obi_reg_adapter.sv
// ============================================================================
// Module : tb_sdhci_obi_reg_adapter
// Brief  : Directed scoreboard bench for the OBI to SDHCI register adapter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sdhci_obi_reg_adapter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdhci_obi_if u_obi ();
  sdhci_reg_if u_reg ();

  sdhci_obi_reg_adapter u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .obi    (u_obi),
    .regb   (u_reg)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } acc_t;

  resp_t resp_q[$];
  acc_t  acc_q[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_cycles = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one request, push the expected register access and response, and
  // complete the handshake. lat<0 means the register model never answers.
  task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                       input logic [31:0] wdata, input int lat, input logic [31:0] mrdata,
                       input logic merr, input bit hold_req);
    resp_t r;
    acc_t  a;
    u_obi.req   = 1'b1;
    u_obi.addr  = addr;
    u_obi.we    = we;
    u_obi.be    = be;
    u_obi.wdata = wdata;
    chk("gnt_idle", 32'(u_obi.gnt), 32'd1);
    if (addr[31:8] != 24'd0) begin
      r.rdata = we ? 32'd0 : 32'hBADCAB1E;
      r.err = 1'b1;
      exp_cycles = 0;
    end else begin
      a.addr = {addr[7:2], 2'b00};
      a.we = we;
      a.be = be;
      a.wdata = wdata;
      acc_q.push_back(a);
      if (lat < 1 || lat > 16) begin
        r.rdata = we ? 32'd0 : 32'hBADCAB1E;
        r.err = 1'b1;
        exp_cycles = 16;
      end else begin
        r.rdata = we ? 32'd0 : mrdata;
        r.err = merr;
        exp_cycles = lat;
      end
    end
    resp_q.push_back(r);
    @(negedge clk);
    if (!hold_req) u_obi.req = 1'b0;
  endtask

  task automatic serve(input int lat, input logic [31:0] mrdata, input logic merr);
    int   n = 0;
    int   iters = 0;
    acc_t a;
    while (!u_obi.rvalid && iters < 40) begin
      if (u_reg.valid) begin
        n++;
        if (n == 1) begin
          if (acc_q.size() == 0) begin
            chk("unexpected_reg_access", 32'(u_reg.valid), 32'd0);
          end else begin
            a = acc_q.pop_front();
            chk("reg_addr", 32'(u_reg.addr), 32'(a.addr));
            chk("reg_we", 32'(u_reg.we), 32'(a.we));
            chk("reg_be", 32'(u_reg.be), 32'(a.be));
            chk("reg_wdata", u_reg.wdata, a.wdata);
          end
        end
        if (n == lat) begin
          u_reg.ready = 1'b1;
          u_reg.rdata = mrdata;
          u_reg.error = merr;
        end
      end
      @(negedge clk);
      u_reg.ready = 1'b0;
      u_reg.rdata = 32'hFFFF_FFFF;
      u_reg.error = 1'b0;
      iters++;
    end
    chk("rvalid_seen", 32'(u_obi.rvalid), 32'd1);
    chk("reg_valid_cycles", 32'(n), 32'(exp_cycles));
    chk("resp_latency", 32'(iters), 32'(exp_cycles));
    chk("reg_valid_dropped", 32'(u_reg.valid), 32'd0);
  endtask

  task automatic respond(input int delay);
    resp_t r;
    for (int i = 0; i < delay; i++) begin
      chk("rvalid_held", 32'(u_obi.rvalid), 32'd1);
      chk("gnt_busy", 32'(u_obi.gnt), 32'd0);
      @(negedge clk);
    end
    r = resp_q.pop_front();
    chk("resp_rdata", u_obi.rdata, r.rdata);
    chk("resp_err", 32'(u_obi.err), 32'(r.err));
    u_obi.rready = 1'b1;
    @(negedge clk);
    u_obi.rready = 1'b0;
    chk("rvalid_cleared", 32'(u_obi.rvalid), 32'd0);
    chk("gnt_back", 32'(u_obi.gnt), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    u_obi.req = 1'b0; u_obi.addr = '0; u_obi.we = 1'b0; u_obi.be = '0;
    u_obi.wdata = '0; u_obi.rready = 1'b0;
    u_reg.ready = 1'b0; u_reg.rdata = 32'hFFFF_FFFF; u_reg.error = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_rvalid", 32'(u_obi.rvalid), 32'd0);
    chk("rst_reg_valid", 32'(u_reg.valid), 32'd0);
    chk("rst_rdata", u_obi.rdata, 32'd0);
    chk("rst_err", 32'(u_obi.err), 32'd0);
    chk("rst_reg_addr", 32'(u_reg.addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // write, register ready in the first ACCESS cycle; rdata must read back 0
    issue(32'h0000_000C, 1'b1, 4'b1100, 32'h1A1B_0000, 1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    serve(1, 32'hFFFF_FFFF, 1'b0);
    respond(0);

    // read with 3-cycle register latency
    issue(32'h0000_0030, 1'b0, 4'b1111, 32'h0, 3, 32'h0001_0002, 1'b0, 1'b0);
    serve(3, 32'h0001_0002, 1'b0);
    respond(0);

    // out-of-range read and write
    issue(32'h0000_0100, 1'b0, 4'b1111, 32'h0, 1, 32'h0, 1'b0, 1'b0);
    serve(1, 32'h0, 1'b0);
    respond(0);
    issue(32'h1000_0004, 1'b1, 4'b0011, 32'h5555_AAAA, 1, 32'h0, 1'b0, 1'b0);
    serve(1, 32'h0, 1'b0);
    respond(0);

    // register never ready: timeout
    issue(32'h0000_0024, 1'b0, 4'b1111, 32'h0, -1, 32'h0, 1'b0, 1'b0);
    serve(-1, 32'h0, 1'b0);
    respond(0);

    // ready on the final allowed cycle completes normally
    issue(32'h0000_0048, 1'b0, 4'b1111, 32'h0, 16, 32'h1234_5678, 1'b0, 1'b0);
    serve(16, 32'h1234_5678, 1'b0);
    respond(0);

    // top of map, low address bits ignored, register error on a read
    issue(32'h0000_00FF, 1'b0, 4'b0001, 32'h0, 2, 32'hCAFE_F00D, 1'b1, 1'b0);
    serve(2, 32'hCAFE_F00D, 1'b1);
    respond(0);

    // be==0 write still forwarded; register error returned, rdata 0
    issue(32'h0000_0010, 1'b1, 4'b0000, 32'hDEAD_BEEF, 1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    serve(1, 32'hFFFF_FFFF, 1'b1);
    respond(0);

    // back-to-back writes, req held, first response stalled for 4 cycles
    issue(32'h0000_0004, 1'b1, 4'b1111, 32'h1111_1111, 1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    u_obi.addr = 32'h0000_0008;
    u_obi.wdata = 32'h2222_2222;
    serve(1, 32'hFFFF_FFFF, 1'b0);
    respond(4);
    issue(32'h0000_0008, 1'b1, 4'b1111, 32'h2222_2222, 2, 32'hFFFF_FFFF, 1'b0, 1'b0);
    serve(2, 32'hFFFF_FFFF, 1'b0);
    respond(0);

    // asynchronous reset during ACCESS of a read
    issue(32'h0000_0040, 1'b0, 4'b1111, 32'h0, -1, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_reg_valid", 32'(u_reg.valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_reg_valid", 32'(u_reg.valid), 32'd0);
    chk("async_rst_rvalid", 32'(u_obi.rvalid), 32'd0);
    void'(resp_q.pop_front());
    void'(acc_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt", 32'(u_obi.gnt), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_no_rvalid", 32'(u_obi.rvalid), 32'd0);
      chk("post_rst_no_reg_valid", 32'(u_reg.valid), 32'd0);
      @(negedge clk);
    end

    chk("scoreboard_empty", 32'(resp_q.size() + acc_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
